// File: rtl/mem_interface.sv
// mem_interface: memory-side stage that turns control strobes into a req/ack
// access to a variable-latency unified memory and captures the results into IR
// or MDR. Optional macro MEM_IF_TIMEOUT_EN adds a wait counter that aborts an
// access after TIMEOUT cycles without ack.
module mem_interface #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              IoD,
  input  logic              MemR,
  input  logic              MemW,
  input  logic              IRWrite,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic [6:0]        input_control,
  output logic              busy,
  output logic              mem_err
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  state_t            r_state, w_next;
  logic              r_mem_req, r_mem_we, r_dest_ir, r_mem_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_ir, r_mdr;
  logic              w_strb, w_illegal, w_start, w_finish, w_timeout;
  assign w_strb    = IRWrite | MemR | MemW;
  assign w_illegal = MemW & (MemR | IRWrite);
  assign w_start   = (r_state == S_IDLE) && w_strb && !w_illegal;
  assign w_finish  = (r_state == S_WAIT) && (mem_ack || w_timeout);
`ifdef MEM_IF_TIMEOUT_EN
  logic [15:0] r_cnt;
  // Count WAIT cycles; the counter sits at zero whenever no access is pending
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) r_cnt <= '0;
    else        r_cnt <= (r_state == S_WAIT) ? r_cnt + 16'd1 : 16'd0;
  assign w_timeout = (r_state == S_WAIT) && (r_cnt == 16'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif
  // State register
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  // Next state: illegal strobes skip WAIT; DONE always returns to IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = !w_strb ? S_IDLE : (w_illegal ? S_DONE : S_WAIT);
      S_WAIT:  w_next = (mem_ack || w_timeout) ? S_DONE : S_WAIT;
      default: w_next = S_IDLE;
    endcase
  end
  // Hold the control FSM while a request is being decoded or is outstanding
  always_comb busy = ((r_state == S_IDLE) && w_strb) || (r_state == S_WAIT);
  // Bus registers, capture registers and sticky error
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_dest_ir   <= 1'b0;
      r_ir        <= '0;
      r_mdr       <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      if (w_start) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= MemW;
        r_mem_addr  <= IoD ? alu_addr : pc;
        r_mem_wdata <= wr_data;
        r_dest_ir   <= IRWrite;
      end else if (w_finish) r_mem_req <= 1'b0;
      if ((r_state == S_WAIT) && mem_ack && !r_mem_we && r_dest_ir)  r_ir  <= mem_rdata;
      if ((r_state == S_WAIT) && mem_ack && !r_mem_we && !r_dest_ir) r_mdr <= mem_rdata;
      if (((r_state == S_IDLE) && w_strb && w_illegal) || (w_timeout && !mem_ack)) r_mem_err <= 1'b1;
    end
  assign mem_req       = r_mem_req;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign ir            = r_ir;
  assign mdr           = r_mdr;
  assign mem_err       = r_mem_err;
  assign input_control = {r_ir[6:3], r_ir[2:0]};
endmodule

// File: tb/tb_mem_interface.sv
// tb_mem_interface: table-driven per-cycle vectors plus hand-written reset,
// late-ack and timeout sequences for mem_interface (TIMEOUT = 8).
module tb_mem_interface;
  logic        CLK = 1'b0, Reset = 1'b0;
  logic        IoD = 0, MemR = 0, MemW = 0, IRWrite = 0, mem_ack = 0;
  logic [15:0] pc = 0, alu_addr = 0, wr_data = 0, mem_rdata = 0;
  logic        mem_req, mem_we, busy, mem_err;
  logic [15:0] mem_addr, mem_wdata, ir, mdr;
  logic [6:0]  input_control;
  int checks = 0, errors = 0;

  mem_interface #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(8)) dut (
    .CLK(CLK), .Reset(Reset), .IoD(IoD), .MemR(MemR), .MemW(MemW), .IRWrite(IRWrite),
    .pc(pc), .alu_addr(alu_addr), .wr_data(wr_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ir(ir), .mdr(mdr), .input_control(input_control), .busy(busy), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        iod, memr, memw, irw, ack;
    logic [15:0] pc, alu, wd, rd;
    logic        req, we;
    logic [15:0] addr, wdata;
    logic        busy;
    logic [15:0] ir, mdr;
    logic        err;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    //           iod memr memw irw ack pc       alu      wd       rd        req we addr     wdata    busy ir       mdr      err
    vecs[0]  = '{0, 0, 0, 1, 0, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000, 0};
    vecs[1]  = '{0, 0, 0, 1, 0, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 1, 0, 16'h0010, 16'h0000, 1, 16'h0000, 16'h0000, 0};
    vecs[2]  = '{0, 0, 0, 1, 0, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 1, 0, 16'h0010, 16'h0000, 1, 16'h0000, 16'h0000, 0};
    vecs[3]  = '{0, 0, 0, 1, 1, 16'h0010, 16'h0000, 16'h0000, 16'h1234, 1, 0, 16'h0010, 16'h0000, 1, 16'h0000, 16'h0000, 0};
    vecs[4]  = '{0, 0, 0, 1, 0, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0010, 16'h0000, 0, 16'h1234, 16'h0000, 0};
    vecs[5]  = '{0, 0, 0, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0010, 16'h0000, 0, 16'h1234, 16'h0000, 0};
    vecs[6]  = '{1, 0, 1, 0, 0, 16'h0010, 16'h0200, 16'hBEEF, 16'h0000, 0, 0, 16'h0010, 16'h0000, 1, 16'h1234, 16'h0000, 0};
    vecs[7]  = '{1, 0, 1, 0, 1, 16'h0010, 16'h0200, 16'hBEEF, 16'h9999, 1, 1, 16'h0200, 16'hBEEF, 1, 16'h1234, 16'h0000, 0};
    vecs[8]  = '{0, 0, 0, 0, 0, 16'h0010, 16'h0200, 16'hBEEF, 16'h0000, 0, 1, 16'h0200, 16'hBEEF, 0, 16'h1234, 16'h0000, 0};
    vecs[9]  = '{1, 1, 0, 0, 0, 16'h0010, 16'h0300, 16'hBEEF, 16'h0000, 0, 1, 16'h0200, 16'hBEEF, 1, 16'h1234, 16'h0000, 0};
    vecs[10] = '{1, 1, 0, 0, 0, 16'h0010, 16'h0300, 16'hBEEF, 16'h0000, 1, 0, 16'h0300, 16'hBEEF, 1, 16'h1234, 16'h0000, 0};
    vecs[11] = '{1, 1, 0, 0, 1, 16'h0010, 16'h0300, 16'hBEEF, 16'h00FF, 1, 0, 16'h0300, 16'hBEEF, 1, 16'h1234, 16'h0000, 0};
    vecs[12] = '{1, 1, 0, 0, 0, 16'h0010, 16'h0300, 16'hBEEF, 16'h0000, 0, 0, 16'h0300, 16'hBEEF, 0, 16'h1234, 16'h00FF, 0};
    vecs[13] = '{0, 0, 0, 0, 0, 16'h0010, 16'h0300, 16'hBEEF, 16'h0000, 0, 0, 16'h0300, 16'hBEEF, 0, 16'h1234, 16'h00FF, 0};
    vecs[14] = '{0, 0, 0, 0, 1, 16'h0010, 16'h0300, 16'hBEEF, 16'hDEAD, 0, 0, 16'h0300, 16'hBEEF, 0, 16'h1234, 16'h00FF, 0};
    vecs[15] = '{0, 0, 0, 0, 0, 16'h0010, 16'h0300, 16'hBEEF, 16'h0000, 0, 0, 16'h0300, 16'hBEEF, 0, 16'h1234, 16'h00FF, 0};
    vecs[16] = '{1, 1, 1, 0, 0, 16'h0010, 16'h0400, 16'hBEEF, 16'h0000, 0, 0, 16'h0300, 16'hBEEF, 1, 16'h1234, 16'h00FF, 0};
    vecs[17] = '{1, 1, 1, 0, 0, 16'h0010, 16'h0400, 16'hBEEF, 16'h0000, 0, 0, 16'h0300, 16'hBEEF, 0, 16'h1234, 16'h00FF, 1};
    vecs[18] = '{0, 0, 0, 0, 0, 16'h0010, 16'h0400, 16'hBEEF, 16'h0000, 0, 0, 16'h0300, 16'hBEEF, 0, 16'h1234, 16'h00FF, 1};

    repeat (2) @(negedge CLK);
    chk("rst_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_ir", ir, 0);
    chk("rst_mdr", mdr, 0);
    Reset = 1'b1;

    for (int i = 0; i < 19; i++) begin
      @(negedge CLK);
      IoD = vecs[i].iod; MemR = vecs[i].memr; MemW = vecs[i].memw; IRWrite = vecs[i].irw;
      mem_ack = vecs[i].ack; pc = vecs[i].pc; alu_addr = vecs[i].alu;
      wr_data = vecs[i].wd; mem_rdata = vecs[i].rd;
      #1;
      chk($sformatf("v%0d_req", i), mem_req, vecs[i].req);
      chk($sformatf("v%0d_we", i), mem_we, vecs[i].we);
      chk($sformatf("v%0d_addr", i), mem_addr, vecs[i].addr);
      chk($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].wdata);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("v%0d_ir", i), ir, vecs[i].ir);
      chk($sformatf("v%0d_mdr", i), mdr, vecs[i].mdr);
      chk($sformatf("v%0d_ic", i), 16'(input_control), 16'(vecs[i].ir[6:0]));
      chk($sformatf("v%0d_err", i), mem_err, vecs[i].err);
    end

    // Asynchronous reset in the middle of WAIT, then a late ack
    @(negedge CLK);
    IoD = 1; MemR = 1; alu_addr = 16'h0600;
    @(negedge CLK);
    #1 chk("mid_wait_req", mem_req, 1);
    Reset = 1'b0; MemR = 0;
    #1;
    chk("areset_req", mem_req, 0);
    chk("areset_ir", ir, 0);
    chk("areset_mdr", mdr, 0);
    chk("areset_err", mem_err, 0);
    chk("areset_busy", busy, 0);
    @(negedge CLK);
    mem_ack = 1; mem_rdata = 16'hAAAA;
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    mem_ack = 0;
    #1;
    chk("late_ack_mdr", mdr, 0);
    chk("late_ack_req", mem_req, 0);

    // Ack in the same cycle as the timeout: ack wins
    @(negedge CLK);
    IoD = 0; pc = 16'h0050; MemR = 1;
    @(negedge CLK);
    repeat (7) @(negedge CLK);
    chk("w8_req", mem_req, 1);
    mem_ack = 1; mem_rdata = 16'h5A5A;
    @(negedge CLK);
    mem_ack = 0; MemR = 0;
    #1;
    chk("w8_req_drop", mem_req, 0);
    chk("w8_mdr", mdr, 16'h5A5A);
    chk("w8_err", mem_err, 0);
    chk("w8_busy", busy, 0);

    // No ack at all
    @(negedge CLK);
    MemR = 1;
    @(negedge CLK);
    n = 0;
`ifdef MEM_IF_TIMEOUT_EN
    while (mem_req && n < 300) begin n++; @(negedge CLK); end
    MemR = 0;
    #1;
    chk("to_req_cycles", 16'(n), 16'd8);
    chk("to_err", mem_err, 1);
    chk("to_busy", busy, 0);
    chk("to_mdr", mdr, 16'h5A5A);
`else
    while (mem_req && n < 120) begin n++; @(negedge CLK); end
    chk("nto_req_cycles", 16'(n), 16'd120);
    mem_ack = 1; mem_rdata = 16'hCAFE;
    @(negedge CLK);
    mem_ack = 0; MemR = 0;
    #1;
    chk("nto_req_drop", mem_req, 0);
    chk("nto_mdr", mdr, 16'hCAFE);
    chk("nto_err", mem_err, 0);
    chk("nto_busy", busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
